mem_stage: RTL and testbench

Memory-access stage of the RV32I five-stage pipeline. It takes the EX/MEM pipeline register contents and drives the data-memory request/acknowledge interface. It aligns store data and byte enables, and extracts and sign- or zero-extends load data. It produces the MEM/WB pipeline register that the writeback multiplexer consumes: MemtoReg, memory data, PC+4 and ALU value. While a memory access is outstanding it stalls the upstream stages.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 13 +
 rtl/load_align.sv | 33 +++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the memory stage: funct3 codes, writeback select encodings
// and the memory-access FSM state type.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Stores only have signed-width encodings; loads also accept the unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus. The pipeline stage is the master.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half-word lane of a read word and sign- or zero-extends it.
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_val = rdata;
            F3_BU:   load_val = {24'd0, byte_sel};
            F3_HU:   load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory requests from EX/MEM, waits for the ack (with
// a bus-error timeout), stalls upstream while waiting and loads the MEM/WB register.
module mem_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_EM,
    input  logic        MemRead_EM,
    input  logic        MemWrite_EM,
    input  logic [2:0]  funct3_EM,
    input  logic        RegWrite_EM,
    input  logic [4:0]  rd_EM,
    input  logic [1:0]  MemtoReg_EM,
    input  logic [31:0] ALU_VAL_EM,
    input  logic [31:0] RS2_VAL_EM,
    input  logic [31:0] PC4_EM,
    mem_stage_if.master dmem,
    output logic        stall_MEM,
    output logic        valid_MW,
    output logic        RegWrite_MW,
    output logic [4:0]  rd_MW,
    output logic [1:0]  MemtoReg_MW,
    output logic [31:0] MEM_DATA_MW,
    output logic [31:0] PC4_MW,
    output logic [31:0] ALU_VAL_MW,
    output logic        misalign_MW,
    output logic        buserr_MW
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_op, addr_ok, misalign, issue;
    logic        ack_done, timeout_hit, complete;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_val;

    // Decode the access and decide whether it may go out on the bus
    always_comb begin
        mem_op = valid_EM & (MemRead_EM | MemWrite_EM);
        case (funct3_EM[1:0])
            2'b00:   addr_ok = 1'b1;
            2'b01:   addr_ok = ~ALU_VAL_EM[0];
            2'b10:   addr_ok = (ALU_VAL_EM[1:0] == 2'b00);
            default: addr_ok = 1'b0;
        endcase
        misalign = mem_op & ~(addr_ok & f3_legal(funct3_EM, MemWrite_EM));
        // Gated by reset so an abandoned request drops while reset is held.
        issue    = mem_op & ~misalign & rst_n;
    end

    // Store lane placement; loads read the whole word
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = 32'd0;
        if (MemWrite_EM) begin
            case (funct3_EM[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << ALU_VAL_EM[1:0];
                    lane_wdata = {4{RS2_VAL_EM[7:0]}};
                end
                2'b01: begin
                    lane_be    = 4'b0011 << ALU_VAL_EM[1:0];
                    lane_wdata = {2{RS2_VAL_EM[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = RS2_VAL_EM;
                end
            endcase
        end
    end

    // Bus request fields, combinational from the (stall-held) EX/MEM inputs
    always_comb begin
        dmem.req   = issue;
        dmem.we    = issue & MemWrite_EM;
        dmem.addr  = {ALU_VAL_EM[31:2], 2'b00};
        dmem.be    = issue ? lane_be : 4'b0000;
        dmem.wdata = (issue & MemWrite_EM) ? lane_wdata : 32'd0;
    end

    // FSM state and timeout counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue && !dmem.ack) begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                if (!issue || dmem.ack || (cnt_q == CntLast)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: completion and upstream stall
    always_comb begin
        ack_done    = issue & dmem.ack;
        timeout_hit = (state_q == WAIT) & issue & ~dmem.ack & (cnt_q == CntLast);
        complete    = ack_done | timeout_hit;
        stall_MEM   = issue & ~complete;
    end

    load_align u_load_align (
        .rdata    (dmem.rdata),
        .addr     (ALU_VAL_EM[1:0]),
        .funct3   (funct3_EM),
        .load_val (load_val)
    );

    // MEM/WB register: bubble on stall (data fields held), otherwise load from EX/MEM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_MW    <= 1'b0;
            RegWrite_MW <= 1'b0;
            rd_MW       <= 5'd0;
            MemtoReg_MW <= WB_ALU;
            MEM_DATA_MW <= 32'd0;
            PC4_MW      <= 32'd0;
            ALU_VAL_MW  <= 32'd0;
            misalign_MW <= 1'b0;
            buserr_MW   <= 1'b0;
        end else if (stall_MEM) begin
            valid_MW    <= 1'b0;
            RegWrite_MW <= 1'b0;
            misalign_MW <= 1'b0;
            buserr_MW   <= 1'b0;
        end else begin
            valid_MW    <= valid_EM;
            RegWrite_MW <= valid_EM & RegWrite_EM & ~misalign & ~timeout_hit;
            rd_MW       <= rd_EM;
            MemtoReg_MW <= MemtoReg_EM;
            MEM_DATA_MW <= (ack_done & MemRead_EM) ? load_val : 32'd0;
            PC4_MW      <= PC4_EM;
            ALU_VAL_MW  <= ALU_VAL_EM;
            misalign_MW <= misalign;
            buserr_MW   <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-cycle accesses plus hand-written sequences
// for delayed ack, timeout/late ack and reset during a wait.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_EM, MemRead_EM, MemWrite_EM, RegWrite_EM;
    logic [2:0]  funct3_EM;
    logic [4:0]  rd_EM;
    logic [1:0]  MemtoReg_EM;
    logic [31:0] ALU_VAL_EM, RS2_VAL_EM, PC4_EM;
    logic        stall_MEM, valid_MW, RegWrite_MW, misalign_MW, buserr_MW;
    logic [4:0]  rd_MW;
    logic [1:0]  MemtoReg_MW;
    logic [31:0] MEM_DATA_MW, PC4_MW, ALU_VAL_MW;

    int checks = 0;
    int failures = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_EM    (valid_EM),
        .MemRead_EM  (MemRead_EM),
        .MemWrite_EM (MemWrite_EM),
        .funct3_EM   (funct3_EM),
        .RegWrite_EM (RegWrite_EM),
        .rd_EM       (rd_EM),
        .MemtoReg_EM (MemtoReg_EM),
        .ALU_VAL_EM  (ALU_VAL_EM),
        .RS2_VAL_EM  (RS2_VAL_EM),
        .PC4_EM      (PC4_EM),
        .dmem        (bus.master),
        .stall_MEM   (stall_MEM),
        .valid_MW    (valid_MW),
        .RegWrite_MW (RegWrite_MW),
        .rd_MW       (rd_MW),
        .MemtoReg_MW (MemtoReg_MW),
        .MEM_DATA_MW (MEM_DATA_MW),
        .PC4_MW      (PC4_MW),
        .ALU_VAL_MW  (ALU_VAL_MW),
        .misalign_MW (misalign_MW),
        .buserr_MW   (buserr_MW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [31:0] pc4);
        valid_EM    = 1'b1;
        MemRead_EM  = rd_en;
        MemWrite_EM = wr_en;
        funct3_EM   = f3;
        RegWrite_EM = ~wr_en;
        MemtoReg_EM = rd_en ? 2'b01 : 2'b00;
        rd_EM       = rd;
        ALU_VAL_EM  = addr;
        RS2_VAL_EM  = rs2;
        PC4_EM      = pc4;
    endtask

    task automatic idle_inputs();
        valid_EM    = 1'b0;
        MemRead_EM  = 1'b0;
        MemWrite_EM = 1'b0;
        funct3_EM   = 3'b000;
        RegWrite_EM = 1'b0;
        MemtoReg_EM = 2'b00;
        rd_EM       = 5'd0;
        ALU_VAL_EM  = 32'd0;
        RS2_VAL_EM  = 32'd0;
        PC4_EM      = 32'd0;
        bus.ack     = 1'b0;
        bus.rdata   = 32'd0;
    endtask

    task automatic chk_mw_zero(input string tag);
        chk({tag, " valid_MW"}, 32'(valid_MW), 32'd0);
        chk({tag, " RegWrite_MW"}, 32'(RegWrite_MW), 32'd0);
        chk({tag, " rd_MW"}, 32'(rd_MW), 32'd0);
        chk({tag, " MemtoReg_MW"}, 32'(MemtoReg_MW), 32'd0);
        chk({tag, " MEM_DATA_MW"}, MEM_DATA_MW, 32'd0);
        chk({tag, " PC4_MW"}, PC4_MW, 32'd0);
        chk({tag, " ALU_VAL_MW"}, ALU_VAL_MW, 32'd0);
        chk({tag, " misalign_MW"}, 32'(misalign_MW), 32'd0);
        chk({tag, " buserr_MW"}, 32'(buserr_MW), 32'd0);
        chk({tag, " req"}, 32'(bus.req), 32'd0);
    endtask

    initial begin
        //            rd wr f3      addr          rs2           rdata         ack
        //            req we be       wdata         rw data          mis
        vecs[0]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'hFFFF_FF80, 0};
        vecs[1]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1,
                     1, 1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0, 0};
        vecs[2]  = '{0, 1, 3'b000, 32'h0000_0301, 32'h0000_00EF, 32'h0, 1,
                     1, 1, 4'b0010, 32'hEFEF_EFEF, 0, 32'h0, 0};
        vecs[3]  = '{0, 1, 3'b010, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0, 1,
                     1, 1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0, 0};
        vecs[4]  = '{1, 0, 3'b100, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'h0000_00AA, 0};
        vecs[5]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'hFFFF_80AA, 0};
        vecs[6]  = '{1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'h0000_BBCC, 0};
        vecs[7]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'h80AA_BBCC, 0};
        vecs[8]  = '{1, 0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 1,
                     1, 0, 4'b1111, 32'h0, 1, 32'h0000_007F, 0};
        vecs[9]  = '{1, 0, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 0,
                     0, 0, 4'b0000, 32'h0, 0, 32'h0, 1};
        vecs[10] = '{1, 0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0,
                     0, 0, 4'b0000, 32'h0, 0, 32'h0, 1};
        vecs[11] = '{0, 1, 3'b101, 32'h0000_0400, 32'h1111_2222, 32'h0, 0,
                     0, 0, 4'b0000, 32'h0, 0, 32'h0, 1};
        vecs[12] = '{1, 0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0,
                     0, 0, 4'b0000, 32'h0, 0, 32'h0, 1};
        vecs[13] = '{0, 0, 3'b000, 32'h0000_0055, 32'h0000_FFFF, 32'h0, 0,
                     0, 0, 4'b0000, 32'h0, 1, 32'h0, 0};
        vecs[14] = '{0, 1, 3'b001, 32'h0000_0200, 32'h0000_8001, 32'h0, 1,
                     1, 1, 4'b0011, 32'h8001_8001, 0, 32'h0, 0};

        // Reset
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk_mw_zero("reset");
        rst_n = 1'b1;

        // Single-cycle table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rd_en, vecs[i].wr_en, vecs[i].f3, vecs[i].addr, vecs[i].rs2,
                  5'(i + 1), 32'h1000 + 32'(i * 4));
            bus.ack   = vecs[i].ack;
            bus.rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d req", i), 32'(bus.req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d we", i), 32'(bus.we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d be", i), 32'(bus.be), 32'(vecs[i].e_be));
            chk($sformatf("v%0d wdata", i), bus.wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d stall", i), 32'(stall_MEM), 32'd0);
            if (vecs[i].e_req)
                chk($sformatf("v%0d addr", i), bus.addr, vecs[i].addr & 32'hFFFF_FFFC);
            step();
            chk($sformatf("v%0d valid_MW", i), 32'(valid_MW), 32'd1);
            chk($sformatf("v%0d RegWrite_MW", i), 32'(RegWrite_MW), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d MEM_DATA_MW", i), MEM_DATA_MW, vecs[i].e_data);
            chk($sformatf("v%0d misalign_MW", i), 32'(misalign_MW), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d buserr_MW", i), 32'(buserr_MW), 32'd0);
            chk($sformatf("v%0d rd_MW", i), 32'(rd_MW), 32'(i + 1));
            chk($sformatf("v%0d MemtoReg_MW", i), 32'(MemtoReg_MW),
                vecs[i].rd_en ? 32'd1 : 32'd0);
            chk($sformatf("v%0d PC4_MW", i), PC4_MW, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d ALU_VAL_MW", i), ALU_VAL_MW, vecs[i].addr);
        end

        // LW with ack three cycles late: three stall cycles, three bubbles, data held
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd20, 32'h2000);
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("late%0d stall", c), 32'(stall_MEM), 32'd1);
            chk($sformatf("late%0d req", c), 32'(bus.req), 32'd1);
            chk($sformatf("late%0d addr", c), bus.addr, 32'h0000_0500);
            step();
            chk($sformatf("late%0d valid_MW", c), 32'(valid_MW), 32'd0);
            chk($sformatf("late%0d RegWrite_MW", c), 32'(RegWrite_MW), 32'd0);
            chk($sformatf("late%0d PC4_MW held", c), PC4_MW, 32'h1000 + 32'(14 * 4));
        end
        bus.ack   = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
        #1;
        chk("late stall at ack", 32'(stall_MEM), 32'd0);
        step();
        chk("late valid_MW", 32'(valid_MW), 32'd1);
        chk("late RegWrite_MW", 32'(RegWrite_MW), 32'd1);
        chk("late MEM_DATA_MW", MEM_DATA_MW, 32'hCAFE_F00D);
        chk("late rd_MW", 32'(rd_MW), 32'd20);

        // No ack ever with TIMEOUT=4: four stall cycles, then bus error
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd21, 32'h3000);
        bus.ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to%0d stall", c), 32'(stall_MEM), 32'd1);
            step();
            chk($sformatf("to%0d valid_MW", c), 32'(valid_MW), 32'd0);
        end
        #1;
        chk("to final stall", 32'(stall_MEM), 32'd0);
        chk("to final req", 32'(bus.req), 32'd1);
        step();
        chk("to buserr_MW", 32'(buserr_MW), 32'd1);
        chk("to RegWrite_MW", 32'(RegWrite_MW), 32'd0);
        chk("to valid_MW", 32'(valid_MW), 32'd1);
        chk("to MEM_DATA_MW", MEM_DATA_MW, 32'd0);
        // Late ack after the abort goes nowhere
        idle_inputs();
        bus.ack   = 1'b1;
        bus.rdata = 32'hBAD0_BAD0;
        #1;
        chk("lateack req", 32'(bus.req), 32'd0);
        chk("lateack stall", 32'(stall_MEM), 32'd0);
        step();
        chk("lateack valid_MW", 32'(valid_MW), 32'd0);
        chk("lateack buserr_MW", 32'(buserr_MW), 32'd0);
        chk("lateack MEM_DATA_MW", MEM_DATA_MW, 32'd0);
        // FSM back in IDLE: a same-cycle ack completes without stalling
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0610, 32'h0, 5'd22, 32'h3004);
        bus.ack   = 1'b1;
        bus.rdata = 32'h0BAD_F00D;
        #1;
        chk("idle again stall", 32'(stall_MEM), 32'd0);
        step();
        chk("idle again MEM_DATA_MW", MEM_DATA_MW, 32'h0BAD_F00D);
        chk("idle again buserr_MW", 32'(buserr_MW), 32'd0);

        // Reset while waiting abandons the request
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd23, 32'h4000);
        bus.ack = 1'b0;
        #1;
        chk("rstwait stall", 32'(stall_MEM), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk_mw_zero("rstwait");
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("rstwait released req", 32'(bus.req), 32'd0);
        step();
        chk("rstwait released valid_MW", 32'(valid_MW), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
